// File: rtl/sigma_delta_dac_mc_if.sv
// Sample bus and 1-bit output group between the machine core and the sigma-delta DAC.
interface sigma_delta_dac_mc_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16
);
    logic [CHANNELS*WIDTH-1:0] sample_in;
    logic                      sample_stb;
    logic                      mode;
    logic                      mute;
    logic [CHANNELS-1:0]       dac_out;
    logic                      muted;

    modport master (
        output sample_in, sample_stb, mode, mute,
        input  dac_out, muted
    );

    modport slave (
        input  sample_in, sample_stb, mode, mute,
        output dac_out, muted
    );
endinterface

// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel 1-bit sigma-delta DAC: per-channel hold/ramp level feeding a
// selectable first-order (carry) or second-order (saturating) modulator.
module sigma_delta_dac_mc #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 16,
    parameter int SIGNED_IN = 0,
    parameter int RAMP_STEP = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    sigma_delta_dac_mc_if.slave  bus
);
    localparam int AW = WIDTH + 4;
    localparam int EW = WIDTH + 6;

    localparam logic [WIDTH-1:0] MID      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] CLAMP_LO = {4'b0001, {(WIDTH-4){1'b0}}};
    localparam logic [WIDTH-1:0] CLAMP_HI = {4'b1111, {(WIDTH-4){1'b0}}};
    localparam logic [WIDTH:0]   STEP     = RAMP_STEP[WIDTH:0];

    localparam logic signed [EW-1:0] F_FULL = {{(EW-WIDTH-1){1'b0}}, 1'b1, {WIDTH{1'b0}}};
    localparam logic signed [EW-1:0] I_MAX  = {{(EW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [EW-1:0] I_MIN  = {{(EW-AW+1){1'b1}}, {(AW-1){1'b0}}};

    function automatic logic signed [AW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > I_MAX) begin
            return I_MAX[AW-1:0];
        end else if (v < I_MIN) begin
            return I_MIN[AW-1:0];
        end
        return v[AW-1:0];
    endfunction

    logic                r_mode_copy;
    logic                r_muted;
    logic                w_mode_chg;
    logic [CHANNELS-1:0] w_q;
    logic [CHANNELS-1:0] w_at_mid;

    assign w_mode_chg  = (bus.mode != r_mode_copy);
    assign bus.dac_out = w_q;
    assign bus.muted   = r_muted;

    always_ff @(posedge clk_sys) begin
        r_mode_copy <= bus.mode;
        if (reset) begin
            r_muted <= 1'b0;
        end else begin
            r_muted <= bus.mute && (&w_at_mid);
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [WIDTH-1:0]       r_hold, r_level, r_acc;
        logic [WIDTH-1:0]       w_sample, w_target, w_level_next, w_lvl2;
        logic [WIDTH:0]         w_diff, w_acc_next;
        logic                   w_up, r_q;
        logic signed [AW-1:0]   r_i1, r_i2, w_i1_next, w_i2_next;
        logic signed [EW-1:0]   w_fb, w_s1, w_s2;

        // Signed input becomes offset-binary by flipping the MSB.
        assign w_sample = bus.sample_in[gi*WIDTH +: WIDTH] ^ {(SIGNED_IN != 0), {(WIDTH-1){1'b0}}};
        assign w_target = bus.mute ? MID : r_hold;
        assign w_up     = (w_target > r_level);
        assign w_diff   = w_up ? {1'b0, w_target - r_level} : {1'b0, r_level - w_target};

        always_comb begin
            w_level_next = w_target;
            if (RAMP_STEP != 0 && w_diff > STEP) begin
                w_level_next = w_up ? (r_level + STEP[WIDTH-1:0]) : (r_level - STEP[WIDTH-1:0]);
            end
        end

        // First-order: the carry out of the phase accumulator lives in r_q.
        assign w_acc_next = {1'b0, r_acc} + {1'b0, r_level};

        assign w_lvl2 = (r_level < CLAMP_LO) ? CLAMP_LO :
                        (r_level > CLAMP_HI) ? CLAMP_HI : r_level;
        assign w_fb   = r_q ? F_FULL : '0;

        always_comb begin
            w_s1      = $signed({{(EW-AW){r_i1[AW-1]}}, r_i1})
                      + $signed({{(EW-WIDTH){1'b0}}, w_lvl2}) - w_fb;
            w_i1_next = sat(w_s1);
            w_s2      = $signed({{(EW-AW){r_i2[AW-1]}}, r_i2})
                      + $signed({{(EW-AW){w_i1_next[AW-1]}}, w_i1_next}) - w_fb;
            w_i2_next = sat(w_s2);
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_hold  <= MID;
                r_level <= MID;
                r_acc   <= '0;
                r_i1    <= '0;
                r_i2    <= '0;
                r_q     <= 1'b0;
            end else begin
                if (bus.sample_stb) begin
                    r_hold <= w_sample;
                end
                r_level <= w_level_next;
                if (w_mode_chg) begin
                    r_acc <= '0;
                    r_i1  <= '0;
                    r_i2  <= '0;
                    r_q   <= 1'b0;
                end else if (r_mode_copy) begin
                    r_i1 <= w_i1_next;
                    r_i2 <= w_i2_next;
                    r_q  <= ~w_i2_next[AW-1];
                end else begin
                    r_acc <= w_acc_next[WIDTH-1:0];
                    r_q   <= w_acc_next[WIDTH];
                end
            end
        end

        assign w_q[gi]      = r_q;
        assign w_at_mid[gi] = (r_level == MID);
    end
endmodule

// File: tb/tb_sigma_delta_dac_mc.sv
// Scoreboard bench: stimulus queues expected ones-counts, a monitor counts DAC bits and compares.
module tb_sigma_delta_dac_mc;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sigma_delta_dac_mc_if #(.CHANNELS(2), .WIDTH(8)) if_a ();
    sigma_delta_dac_mc_if #(.CHANNELS(1), .WIDTH(8)) if_b ();
    sigma_delta_dac_mc_if #(.CHANNELS(1), .WIDTH(8)) if_c ();

    sigma_delta_dac_mc #(.CHANNELS(2), .WIDTH(8), .SIGNED_IN(0), .RAMP_STEP(0))
        dut_a (.clk_sys(clk), .reset(reset), .bus(if_a));
    sigma_delta_dac_mc #(.CHANNELS(1), .WIDTH(8), .SIGNED_IN(1), .RAMP_STEP(0))
        dut_b (.clk_sys(clk), .reset(reset), .bus(if_b));
    sigma_delta_dac_mc #(.CHANNELS(1), .WIDTH(8), .SIGNED_IN(0), .RAMP_STEP(16))
        dut_c (.clk_sys(clk), .reset(reset), .bus(if_c));

    typedef struct {
        string name;
        int    sel;
        int    ncyc;
        int    exp_v;
        int    tol;
    } exp_t;

    exp_t exp_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;

    function automatic int probe(int sel);
        case (sel)
            0:       return int'(if_a.dac_out[0]);
            1:       return int'(if_a.dac_out[1]);
            2:       return int'(if_b.dac_out[0]);
            3:       return int'(if_c.dac_out[0]);
            4:       return int'(if_c.muted);
            5:       return int'(if_a.dac_out);
            default: return int'(if_a.muted);
        endcase
    endfunction

    // Monitor: counts the selected output over the requested window, then scores it.
    initial begin
        forever begin : mon_blk
            exp_t e;
            int   acc;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q[0];
                acc = probe(e.sel);
                for (int k = 1; k < e.ncyc; k++) begin
                    @(negedge clk);
                    acc += probe(e.sel);
                end
                void'(exp_q.pop_front());
                total++;
                if (acc < e.exp_v - e.tol || acc > e.exp_v + e.tol) begin
                    bad++;
                    $display("FAIL %s: got %0d want %0d (+/-%0d)", e.name, acc, e.exp_v, e.tol);
                end else begin
                    $display("ok   %s: got %0d want %0d (+/-%0d)", e.name, acc, e.exp_v, e.tol);
                end
                done_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int sel, input int ncyc,
                         input int exp_v, input int tol);
        exp_t e;
        int   target;
        int   waited;
        e.name  = name;
        e.sel   = sel;
        e.ncyc  = ncyc;
        e.exp_v = exp_v;
        e.tol   = tol;
        target  = done_cnt + 1;
        waited  = 0;
        exp_q.push_back(e);
        while (done_cnt < target && waited < ncyc + 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (done_cnt < target) begin
            total++;
            bad++;
            $display("FAIL %s: monitor timeout after %0d cycles, want result", name, waited);
        end
    endtask

    task automatic stb_a(input logic [15:0] v);
        if_a.sample_in  = v;
        if_a.sample_stb = 1'b1;
        tick(1);
        if_a.sample_stb = 1'b0;
    endtask

    task automatic stb_b(input logic [7:0] v);
        if_b.sample_in  = v;
        if_b.sample_stb = 1'b1;
        tick(1);
        if_b.sample_stb = 1'b0;
    endtask

    task automatic stb_c(input logic [7:0] v);
        if_c.sample_in  = v;
        if_c.sample_stb = 1'b1;
        tick(1);
        if_c.sample_stb = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        if_a.sample_in = 16'h8080; if_a.sample_stb = 1'b0; if_a.mode = 1'b0; if_a.mute = 1'b0;
        if_b.sample_in = 8'h00;    if_b.sample_stb = 1'b0; if_b.mode = 1'b0; if_b.mute = 1'b0;
        if_c.sample_in = 8'h80;    if_c.sample_stb = 1'b0; if_c.mode = 1'b0; if_c.mute = 1'b0;
        tick(2);
        check("rst_dac_a",   5, 1, 0, 0);
        check("rst_muted_a", 6, 1, 0, 0);
        check("rst_dac_c",   3, 1, 0, 0);
        reset = 1'b0;
        tick(1);

        // First-order exact density
        stb_a({8'hC0, 8'h40});
        tick(3);
        check("fo_ch0_0x40", 0, 256, 64, 0);
        check("fo_ch1_0xC0", 1, 256, 192, 0);

        // Signed input conversion
        stb_b(8'h80);
        tick(3);
        check("sgn_m128", 2, 256, 0, 0);
        stb_b(8'h7F);
        tick(3);
        check("sgn_p127", 2, 256, 255, 0);
        stb_b(8'h00);
        tick(3);
        check("sgn_zero", 2, 256, 128, 0);

        // Mute ramp: 0xF0 -> 0x80 in 7 steps of 16, muted one cycle later
        stb_c(8'hF0);
        tick(10);
        check("c_0xF0_pre", 3, 256, 240, 0);
        if_c.mute = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check($sformatf("mute_step%0d", k), 4, 1, (k == 8) ? 1 : 0, 0);
        end
        check("muted_count", 3, 256, 128, 0);
        if_c.mute = 1'b0;
        tick(1);
        check("unmute_flag", 4, 1, 0, 0);
        tick(8);
        check("c_0xF0_post", 3, 256, 240, 0);

        // Second-order modulator with clamp on ch1
        stb_a({8'h00, 8'h80});
        tick(3);
        if_a.mode = 1'b1;
        tick(1);
        check("mode1_clear", 5, 1, 0, 0);
        tick(400);
        check("so_ch0_0x80", 0, 256, 128, 2);
        check("so_ch1_clamp", 1, 256, 16, 2);

        // Back to first order: cleared, then exact again
        if_a.mode = 1'b0;
        tick(1);
        check("mode0_clear", 5, 1, 0, 0);
        check("fo_again_ch0", 0, 256, 128, 0);
        check("fo_again_ch1", 1, 256, 0, 0);

        // Reset mid-ramp with a coincident strobe discards the sample
        stb_c(8'h20);
        tick(3);
        reset = 1'b1;
        if_c.sample_in  = 8'hFF;
        if_c.sample_stb = 1'b1;
        tick(1);
        check("rst_mid_dac", 3, 1, 0, 0);
        reset = 1'b0;
        if_c.sample_stb = 1'b0;
        check("rst_mid_muted", 4, 1, 0, 0);
        tick(3);
        check("rst_hold_mid", 3, 256, 128, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sigma_delta_dac_mc.md
Name: sigma_delta_dac_mc

Overview:
Parametrised multi-channel sigma-delta audio DAC driving the 1-bit AUDIO_L/AUDIO_R pins from core sample words, such as the 10-bit machine sound bus. It generalises the fixed single-width stereo path. Added capabilities:
- configurable width and channel count
- signed or unsigned input
- selectable first-order or second-order modulator
- click-free mute ramp
It sits at the top level between the machine core and the audio pins, in the clk_sys domain.

Parameters:
CHANNELS, 2, number of independent modulator channels (1..8)
WIDTH, 16, sample width in bits (8..24)
SIGNED_IN, 0, 1 = two's-complement input, 0 = offset-binary input
RAMP_STEP, 16, per-cycle level step used when ramping toward a new target; 0 = jump immediately

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
sample_in  in  CHANNELS*WIDTH  packed samples; channel n occupies bits [n*WIDTH +: WIDTH]
sample_stb  in  1  one-cycle strobe that latches sample_in for all channels
mode  in  1  0 = first-order modulator, 1 = second-order modulator
mute  in  1  1 = ramp all channels to midscale
dac_out  out  CHANNELS  1-bit modulator outputs, bit n = channel n
muted  out  1  1 when mute=1 and every channel level equals midscale

Behaviour:
Definitions:
- MID = 2^(WIDTH-1).
- Output bit q of a channel is 0 or 1.
- Feedback F = q ? 2^WIDTH : 0.

Reset (reset=1 at an edge):
- dac_out=0, muted=0.
- Per channel: hold register = MID, level register = MID, all integrators = 0.
- Registered mode copy = mode.
- Reset mid-ramp or mid-stream takes effect on that edge, with no residual state.

Input capture:
- On sample_stb=1, hold[n] <= sample_in slice n.
- If SIGNED_IN=1, the MSB is inverted on capture (conversion to offset-binary).
- Without a strobe the hold value persists indefinitely.

Level and ramp:
- Target[n] = mute ? MID : hold[n].
- Each cycle, level[n] moves toward Target[n] by min(RAMP_STEP, |Target - level|), so it never overshoots.
- RAMP_STEP=0: level[n] <= Target[n] directly.
- Latency from sample_stb to level update is 1 cycle for hold, then 1 cycle for level (immediate or first ramp step).
- sample_stb together with mute=1: the sample is still latched; the ramp continues toward MID and resumes toward the new hold value when mute falls.

First-order (mode=0):
- Integrator acc is WIDTH+1 bits.
- acc <= {1'b0, acc[WIDTH-1:0]} + level; q <= carry (new acc[WIDTH]).
- For constant level L, exactly L ones are produced per 2^WIDTH cycles, counted after the first full period.

Second-order (mode=1):
- Signed integrators i1 and i2, each WIDTH+4 bits.
- i1 <= i1 + level - F.
- i2 <= i2 + i1_new - F.
- q <= (i2_new >= 0).
- Level is restricted internally to [2^(WIDTH-4), 2^WIDTH - 2^(WIDTH-4)] for stability. This clamp applies only in mode 1.
- Integrators saturate at their signed limits and never wrap.

Mode change:
- When mode differs from its registered copy, all integrators and q are cleared on that edge and the copy is updated.
- Modulation restarts on the next cycle.

Outputs:
- dac_out is registered directly from q, with no combinational path from any input.
- muted is registered.

Channels:
- Channels are fully independent.
- sample_stb and mute are shared across channels.

Test Plan:
1. WIDTH=8, CHANNELS=2, RAMP_STEP=0, mode=0: strobe ch0=0x40, ch1=0xC0, wait 2 cycles, then count over 256 cycles -> ch0 exactly 64 ones, ch1 exactly 192 ones.
2. SIGNED_IN=1, WIDTH=8: strobe ch0=0x80 (-128) -> hold=0x00, dac_out[0] constant 0; strobe 0x7F -> 255 ones per 256 cycles.
3. RAMP_STEP=16, level=0xF0, mute asserted -> level decreases by 16 per cycle and reaches 0x80 after 7 cycles; muted rises the following cycle; deassert mute -> returns to 0xF0 in 7 cycles and muted=0 immediately after.
4. mode=1, level 0x80 -> ones count 128±2 per 256 cycles; level 0x00 -> clamped to 0x10, count 16±2 per 256 cycles; integrators never wrap (assertion).
5. Toggle mode mid-stream -> integrators and dac_out read 0 on the next cycle, and the first-order count is exact again over the next 256 cycles.
6. Assert reset mid-ramp with sample_stb=1 in the same cycle -> next cycle dac_out=0, muted=0, hold=MID (the strobed sample is discarded).
